// File: rtl/lcd_text_controller_if.sv
// Character stream handshake between the keyboard decoder (master) and the LCD controller (slave).
interface lcd_text_controller_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/lcd_text_controller.sv
// HD44780 16x2 text controller: power-up wait, init sequence, then character writes with line wrap.
// All LCD-side sequencing advances on rising edges of the slow clk_div, sampled in the clk domain.
module lcd_text_controller #(
    parameter int POWERUP_TICKS    = 64,
    parameter int CLEAR_WAIT_TICKS = 6,
    parameter int COLS             = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_div,
    lcd_text_controller_if.slave        chr,
    output logic                        init_done,
    output logic [7:0]                  lcd_data,
    output logic                        lcd_rs,
    output logic                        lcd_rw,
    output logic                        lcd_en,
    output logic                        lcd_on
);
    typedef enum logic [2:0] {
        S_PWR_WAIT, S_INIT, S_INIT_CLR, S_IDLE, S_WRITE, S_NEWLINE, S_NL_CLR
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    localparam logic [7:0] LP_PWR_LAST = 8'(POWERUP_TICKS - 1);
    localparam logic [7:0] LP_CLR_LAST = 8'(CLEAR_WAIT_TICKS - 1);
    localparam logic [4:0] LP_COLS     = 5'(COLS);

    state_t     r_state, w_state_nx;
    phase_t     r_phase, w_phase_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic [2:0] r_idx, w_idx_nx;
    logic [4:0] r_col, w_col_nx;
    logic       r_line, w_line_nx;
    logic [7:0] r_char, w_char_nx;
    logic [7:0] r_data, w_data_nx;
    logic       r_rs, w_rs_nx;
    logic       r_en, w_en_nx;
    logic       r_ready, w_ready_nx;
    logic       r_done, w_done_nx;
    logic       r_on;
    logic       r_clk_div_q;

    logic       w_tick;
    logic       w_xfer_act;
    logic       w_xfer_rs;
    logic [7:0] w_xfer_byte;
    logic       w_xfer_done;
    logic [4:0] w_col_inc;

    assign w_tick      = clk_div & ~r_clk_div_q;
    assign w_xfer_done = w_tick & w_xfer_act & (r_phase == PH_HOLD);
    assign w_col_inc   = r_col + 5'd1;

    // Byte and register-select for whichever state currently owns the bus
    always_comb begin
        w_xfer_act  = 1'b0;
        w_xfer_rs   = 1'b0;
        w_xfer_byte = '0;
        case (r_state)
            S_INIT: begin
                w_xfer_act = 1'b1;
                case (r_idx)
                    3'd0, 3'd1, 3'd2: w_xfer_byte = 8'h38;
                    3'd3:             w_xfer_byte = 8'h0C;
                    3'd4:             w_xfer_byte = 8'h01;
                    default:          w_xfer_byte = 8'h06;
                endcase
            end
            S_WRITE: begin
                w_xfer_act  = 1'b1;
                w_xfer_rs   = 1'b1;
                w_xfer_byte = r_char;
            end
            S_NEWLINE: begin
                w_xfer_act  = 1'b1;
                w_xfer_byte = r_line ? 8'h01 : 8'hC0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_col_nx   = r_col;
        w_line_nx  = r_line;
        w_char_nx  = r_char;
        w_data_nx  = r_data;
        w_rs_nx    = r_rs;
        w_en_nx    = r_en;
        w_done_nx  = r_done;

        if (w_xfer_act && w_tick) begin
            case (r_phase)
                PH_SETUP: begin
                    w_data_nx  = w_xfer_byte;
                    w_rs_nx    = w_xfer_rs;
                    w_en_nx    = 1'b0;
                    w_phase_nx = PH_PULSE;
                end
                PH_PULSE: begin
                    w_en_nx    = 1'b1;
                    w_phase_nx = PH_HOLD;
                end
                default: begin
                    w_en_nx    = 1'b0;
                    w_phase_nx = PH_SETUP;
                end
            endcase
        end

        case (r_state)
            S_PWR_WAIT: if (w_tick) begin
                if (r_cnt == LP_PWR_LAST) begin
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_state_nx = S_INIT;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_INIT: if (w_xfer_done) begin
                if (r_idx == 3'd4) begin
                    w_idx_nx   = r_idx + 3'd1;
                    w_cnt_nx   = '0;
                    w_state_nx = S_INIT_CLR;
                end else if (r_idx == 3'd5) begin
                    w_done_nx  = 1'b1;
                    w_col_nx   = '0;
                    w_line_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_idx_nx = r_idx + 3'd1;
                end
            end
            S_INIT_CLR: if (w_tick) begin
                if (r_cnt == LP_CLR_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_INIT;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            S_IDLE: if (chr.char_valid && r_ready) begin
                w_char_nx  = chr.char_data;
                w_state_nx = (chr.char_data == 8'h0D) ? S_NEWLINE : S_WRITE;
            end
            S_WRITE: if (w_xfer_done) begin
                w_col_nx   = w_col_inc;
                w_state_nx = (w_col_inc == LP_COLS) ? S_NEWLINE : S_IDLE;
            end
            S_NEWLINE: if (w_xfer_done) begin
                w_col_nx = '0;
                if (!r_line) begin
                    w_line_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_NL_CLR;
                end
            end
            S_NL_CLR: if (w_tick) begin
                if (r_cnt == LP_CLR_LAST) begin
                    w_cnt_nx   = '0;
                    w_line_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: w_state_nx = S_PWR_WAIT;
        endcase

        // Registered ready: high on the first clk spent in IDLE, low the clk after an accept
        w_ready_nx = (w_state_nx == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_PWR_WAIT;
            r_phase     <= PH_SETUP;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_col       <= '0;
            r_line      <= 1'b0;
            r_char      <= '0;
            r_data      <= '0;
            r_rs        <= 1'b0;
            r_en        <= 1'b0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
            r_on        <= 1'b0;
            r_clk_div_q <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_cnt       <= w_cnt_nx;
            r_idx       <= w_idx_nx;
            r_col       <= w_col_nx;
            r_line      <= w_line_nx;
            r_char      <= w_char_nx;
            r_data      <= w_data_nx;
            r_rs        <= w_rs_nx;
            r_en        <= w_en_nx;
            r_ready     <= w_ready_nx;
            r_done      <= w_done_nx;
            r_on        <= 1'b1;
            r_clk_div_q <= clk_div;
        end
    end

    assign chr.char_ready = r_ready;
    assign init_done      = r_done;
    assign lcd_data       = r_data;
    assign lcd_rs         = r_rs;
    assign lcd_rw         = 1'b0;
    assign lcd_en         = r_en;
    assign lcd_on         = r_on;
endmodule

// File: tb/tb_lcd_text_controller.sv
// Scoreboard bench for lcd_text_controller: a character-level LCD model predicts every bus byte,
// and a monitor checks each enable pulse against the predicted byte and its tick spacing.
module tb_lcd_text_controller;
    localparam int PWR   = 64;
    localparam int CLRW  = 6;
    localparam int NCOLS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_div = 1'b0;
    logic       init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [7:0] lcd_data;

    lcd_text_controller_if cif ();

    lcd_text_controller #(
        .POWERUP_TICKS   (PWR),
        .CLEAR_WAIT_TICKS(CLRW),
        .COLS            (NCOLS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_div  (clk_div),
        .chr      (cif),
        .init_done(init_done),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;   // required ticks since previous enable rise; 0 = not checked
    } xfer_t;

    xfer_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    tick_cnt = 0;
    int    last_en_tick = 0;
    bit    run_div = 1'b0;
    int    restart_seq = 0;
    int    m_col = 0;
    int    m_line = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Reference model: what the LCD must see, in terms of characters, lines and columns
    task automatic push(input logic rs, input logic [7:0] d, input int gap);
        xfer_t e;
        e.rs = rs; e.d = d; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic model_newline(input int gap);
        if (m_line == 0) begin
            push(1'b0, 8'hC0, gap);
            m_line = 1;
        end else begin
            push(1'b0, 8'h01, gap);
            m_line = 0;
        end
        m_col = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0D) model_newline(0);
        else begin
            push(1'b1, c, 0);
            m_col++;
            if (m_col == NCOLS) model_newline(3);
        end
    endtask

    task automatic model_init();
        push(1'b0, 8'h38, PWR + 2);
        push(1'b0, 8'h38, 3);
        push(1'b0, 8'h38, 3);
        push(1'b0, 8'h0C, 3);
        push(1'b0, 8'h01, 3);
        push(1'b0, 8'h06, 3 + CLRW);
        m_col = 0;
        m_line = 0;
    endtask

    // clk_div: period 8 clk; counts its own rising edges as ticks
    initial begin
        int ph = 0;
        int seen = 0;
        forever begin
            @(negedge clk);
            if (restart_seq != seen) begin
                seen = restart_seq;
                clk_div = 1'b0;
                tick_cnt = 0;
                ph = 0;
            end else if (run_div) begin
                ph++;
                if (ph == 4) begin
                    ph = 0;
                    clk_div = ~clk_div;
                    if (clk_div) tick_cnt++;
                end
            end
        end
    end

    // Monitor: every enable pulse is popped against the scoreboard
    initial begin
        logic       prev_en = 1'b0;
        logic       cap_rs = 1'b0;
        logic [7:0] cap_d = '0;
        xfer_t      e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 1'b0;
                last_en_tick = 0;
            end else begin
                if (lcd_en && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_xfer: got rs=%0b data=0x%02h want no transfer", lcd_rs, lcd_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_rs", int'(lcd_rs), int'(e.rs));
                        check("xfer_data", int'(lcd_data), int'(e.d));
                        check("xfer_rw", int'(lcd_rw), 0);
                        if (e.gap != 0) check("xfer_tick_gap", tick_cnt - last_en_tick, e.gap);
                    end
                    last_en_tick = tick_cnt;
                    cap_rs = lcd_rs;
                    cap_d = lcd_data;
                end
                if (!lcd_en && prev_en) begin
                    check("en_width_ticks", tick_cnt - last_en_tick, 1);
                    check("hold_data", int'(lcd_data), int'(cap_d));
                    check("hold_rs", int'(lcd_rs), int'(cap_rs));
                end
                prev_en = lcd_en;
            end
        end
    end

    // which: 0 char_ready, 1 lcd_en, 2 init_done, 3 scoreboard drained
    task automatic wait_for(input int which, input string name, input int limit, output int at_tick);
        bit ok = 1'b0;
        at_tick = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            case (which)
                0: ok = cif.char_ready;
                1: ok = lcd_en;
                2: ok = init_done;
                default: ok = (exp_q.size() == 0);
            endcase
            if (ok) begin
                at_tick = tick_cnt;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got no event after %0d clk want event", name, limit);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int t;
        wait_for(0, "ready", 4000, t);
        cif.char_valid = 1'b1;
        cif.char_data = c;
        model_char(c);
        @(negedge clk);
        cif.char_valid = 1'b0;
        check("ready_drop", int'(cif.char_ready), 0);
    endtask

    task automatic run_init();
        int t;
        wait_for(2, "init_done", 3000, t);
        check("init_done_tick", t, last_en_tick + 1);
        check("init_queue_empty", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] c;
        if ($urandom_range(0, 7) == 0) c = 8'h0D;
        else c = 8'($urandom_range(32, 126));
        return c;
    endfunction

    initial begin
        int t;
        cif.char_valid = 1'b0;
        cif.char_data = '0;

        repeat (3) @(negedge clk);
        check("rst_en", int'(lcd_en), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_rw", int'(lcd_rw), 0);
        check("rst_on", int'(lcd_on), 0);
        check("rst_ready", int'(cif.char_ready), 0);
        check("rst_init_done", int'(init_done), 0);

        model_init();
        reset = 1'b0;
        run_div = 1'b1;
        @(negedge clk);
        check("on_after_release", int'(lcd_on), 1);
        run_init();

        // Single character: ready returns on the HOLD tick of its transfer
        send_char(8'h41);
        wait_for(0, "ready_after_A", 4000, t);
        check("ready_return_tick", t, last_en_tick + 1);

        // Fill line 0 ('A' already at col 0) to force a wrap, then continue on line 1
        for (int i = 0; i < 15; i++) send_char(8'(8'h61 + i));
        send_char(8'h71);
        send_char(8'h0D);
        wait_for(0, "ready_after_clear", 4000, t);
        check("clear_wait_tick", t, last_en_tick + 1 + CLRW);
        send_char(8'h78);
        for (int i = 0; i < 15; i++) send_char(8'(8'h41 + i));

        // Stall with clk_div frozen mid-pulse
        send_char(8'h5A);
        wait_for(1, "en_for_stall", 4000, t);
        run_div = 1'b0;
        repeat (200) @(negedge clk);
        check("stall_en", int'(lcd_en), 1);
        check("stall_ready", int'(cif.char_ready), 0);
        run_div = 1'b1;

        for (int i = 0; i < 40; i++) send_char(rand_char());

        // Asynchronous reset during a data pulse
        wait_for(3, "drain_before_reset", 4000, t);
        send_char(8'h52);
        wait_for(1, "en_for_reset", 4000, t);
        #1 reset = 1'b1;
        #1;
        check("async_rst_en", int'(lcd_en), 0);
        check("async_rst_init_done", int'(init_done), 0);
        check("async_rst_ready", int'(cif.char_ready), 0);
        run_div = 1'b0;
        restart_seq++;
        exp_q.delete();
        repeat (5) @(negedge clk);
        model_init();
        reset = 1'b0;
        run_div = 1'b1;
        run_init();
        for (int i = 0; i < 20; i++) send_char(rand_char());

        wait_for(3, "final_drain", 6000, t);
        check("final_queue_empty", exp_q.size(), 0);
        wait_for(0, "final_ready", 4000, t);
        check("final_init_done", int'(init_done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
